// File: rtl/axi_lite_vram_responder.sv
// AXI4-Lite register file for the HDMI text controller: 600 VRAM words plus a
// control word, with an independent registered display read port.
module axi_lite_vram_responder #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int NUM_REGS         = 601
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]                    axi_awprot,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]                    axi_arprot,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  input  logic [9:0]                    disp_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]   disp_data,
  output logic [C_AXI_DATA_WIDTH-1:0]   ctrl_reg
);

  localparam int IDX_W     = 10;
  localparam int NUM_LANES = C_AXI_DATA_WIDTH / 8;
  localparam int LANE_BITS = NUM_REGS * 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_RESP} rd_state_t;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return {22'd0, idx} < 32'(NUM_REGS);
  endfunction

  // ---------------- write path ----------------
  logic                          ready_en_reg;
  logic                          aw_full_reg;
  logic                          w_full_reg;
  logic [IDX_W-1:0]              aw_idx_reg;
  logic [C_AXI_DATA_WIDTH-1:0]   w_data_reg;
  logic [NUM_LANES-1:0]          w_strb_reg;
  logic                          bvalid_reg;
  logic [1:0]                    bresp_reg;

  logic aw_hs, w_hs, b_hs, commit, aw_in_range;

  assign axi_awready = ready_en_reg & ~aw_full_reg & ~bvalid_reg;
  assign axi_wready  = ready_en_reg & ~w_full_reg & ~bvalid_reg;
  assign aw_hs       = axi_awvalid & axi_awready;
  assign w_hs        = axi_wvalid & axi_wready;
  assign b_hs        = bvalid_reg & axi_bready;
  assign commit      = aw_full_reg & w_full_reg & ~bvalid_reg;
  assign aw_in_range = idx_in_range(aw_idx_reg);
  assign axi_bvalid  = bvalid_reg;
  assign axi_bresp   = bresp_reg;

  // ready_en_reg keeps every ready low until the first edge after reset release
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ready_en_reg <= 1'b0;
      aw_full_reg  <= 1'b0;
      w_full_reg   <= 1'b0;
      aw_idx_reg   <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      ready_en_reg <= 1'b1;
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_idx_reg  <= axi_awaddr[11:2];
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= axi_wdata;
        w_strb_reg <= axi_wstrb;
      end
      if (commit) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid_reg  <= 1'b0;
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
      end
    end
  end

  // ---------------- register storage, one byte lane per block ----------------
  logic [IDX_W-1:0]            ar_idx_reg;
  logic                        ar_in_range;
  logic                        disp_in_range;
  logic [IDX_W-1:0]            aw_sel, ar_sel, disp_sel;
  logic [C_AXI_DATA_WIDTH-1:0] rd_word;

  assign ar_in_range   = idx_in_range(ar_idx_reg);
  assign disp_in_range = idx_in_range(disp_addr);
  // Clamp indices so lane part-selects never leave the storage vector
  assign aw_sel   = aw_in_range   ? aw_idx_reg : '0;
  assign ar_sel   = ar_in_range   ? ar_idx_reg : '0;
  assign disp_sel = disp_in_range ? disp_addr  : '0;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [LANE_BITS-1:0] lane_reg;
    logic [7:0]           disp_byte_reg;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
        lane_reg      <= '0;
        disp_byte_reg <= '0;
      end else begin
        if (commit && aw_in_range && w_strb_reg[gi])
          lane_reg[{aw_sel, 3'b000} +: 8] <= w_data_reg[8*gi +: 8];
        disp_byte_reg <= disp_in_range ? lane_reg[{disp_sel, 3'b000} +: 8] : 8'd0;
      end
    end

    assign rd_word[8*gi +: 8]   = lane_reg[{ar_sel, 3'b000} +: 8];
    assign disp_data[8*gi +: 8] = disp_byte_reg;
    assign ctrl_reg[8*gi +: 8]  = lane_reg[(NUM_REGS-1)*8 +: 8];
  end

  // ---------------- read path ----------------
  rd_state_t                   rd_state_reg;
  logic                        rvalid_reg;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]                  rresp_reg;

  assign axi_arready = ready_en_reg & (rd_state_reg == RD_IDLE);
  assign axi_rvalid  = rvalid_reg;
  assign axi_rdata   = rdata_reg;
  assign axi_rresp   = rresp_reg;

  // FETCH samples storage before a same-edge commit lands, so reads see old data
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_state_reg <= RD_IDLE;
      ar_idx_reg   <= '0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
    end else begin
      case (rd_state_reg)
        RD_IDLE: begin
          if (axi_arvalid && ready_en_reg) begin
            ar_idx_reg   <= axi_araddr[11:2];
            rd_state_reg <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          rdata_reg    <= ar_in_range ? rd_word : '0;
          rresp_reg    <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
          rvalid_reg   <= 1'b1;
          rd_state_reg <= RD_RESP;
        end
        RD_RESP: begin
          if (axi_rready) begin
            rvalid_reg   <= 1'b0;
            rd_state_reg <= RD_IDLE;
          end
        end
        default: rd_state_reg <= RD_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{axi_awprot, axi_arprot,
                         axi_awaddr[C_AXI_ADDR_WIDTH-1:12], axi_awaddr[1:0],
                         axi_araddr[C_AXI_ADDR_WIDTH-1:12], axi_araddr[1:0]};

endmodule
